regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
// - Parametrised synchronous register file for the datapath, replacing the fixed 32x32, 2-read design.
// - Configurable width, depth and read-port count; registered (1-cycle) reads; optional hard-wired zero register.
// - Built-in clear sequencer zeroes every entry after reset or on request, with a busy flag for the control unit.
// PARAMETERS
// - DATA_W   32  data width in bits
// - ADDR_W   5   address width; DEPTH = 2**ADDR_W entries
// - NUM_RD   2   number of read ports (1..4)
// - ZERO_REG 1   1: entry 0 reads as 0 and ignores writes; 0: entry 0 is ordinary
// PORTS
// - clk      in   1              rising-edge clock
// - rst_n    in   1              asynchronous active-low reset
// - clr_req  in   1              1-cycle pulse: start clear sequence
// - wr_en    in   1              write enable
// - wr_addr  in   ADDR_W         write address
// - wr_data  in   DATA_W         write data
// - rd_addr  in   NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
// - rd_data  out  NUM_RD*DATA_W  packed registered read data, port p at [p*DATA_W +: DATA_W]
// - busy     out  1              1 while the clear sequence runs
// BEHAVIOUR
// - Reset (rst_n=0, async): rd_data=0, busy=1, FSM=CLEAR, clr_ptr=0; array contents undefined until cleared.
// - FSM states: CLEAR, READY.
//   - CLEAR: each cycle writes 0 to entry clr_ptr, clr_ptr++; at clr_ptr==DEPTH-1 writes it, goes READY next cycle.
//   - Clear takes exactly DEPTH cycles after rst_n rises; busy falls on the cycle the FSM enters READY.
//   - READY: normal operation; clr_req=1 -> CLEAR, clr_ptr=0, busy=1 next cycle.
//   - clr_req during CLEAR ignored (no restart). rst_n low mid-clear: async return to reset state, full restart.
// - Write: in READY, wr_en=1 writes wr_data to wr_addr at posedge. In CLEAR, wr_en ignored (write dropped).
// - ZERO_REG=1: writes to address 0 dropped; reads of address 0 return 0 regardless of array.
// - Read: each port registered; rd_data[p] at edge N+1 reflects rd_addr[p] sampled at edge N, latency 1.
//   - Read value = array content before the write of the same edge (read-old) unless bypass compiled in.
//   - While busy=1 all rd_data update to 0.
// - Multiple ports may address the same entry; all return identical data.
// - No arithmetic; clr_ptr is ADDR_W bits, terminal compare against all-ones, no wrap past DEPTH-1.
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN:
//   - Defined: in READY, if wr_en=1 and rd_addr[p]==wr_addr (and not zero-reg address 0 with ZERO_REG=1),
//     rd_data[p] captures wr_data at the same edge (write-first forwarding).
//   - Undefined: read-old behaviour; same-edge write visible on the following read only.
// TESTING
// - Reset, release rst_n, DATA_W=32 ADDR_W=5: busy=1 for exactly 32 cycles; read all 32 entries -> all 0.
// - Write 0xDEADBEEF to r5, then rd_addr0=5, rd_addr1=5 -> both rd_data=0xDEADBEEF one cycle later.
// - Write 0x12345678 to r0 (ZERO_REG=1), read r0 -> 0; with ZERO_REG=0 -> 0x12345678.
// - Same-edge write 0xA5A5A5A5 to r7 and read r7 (old 0x1): undefined macro -> 0x1; REGFILE_BYPASS_EN -> 0xA5A5A5A5.
// - Fill r1..r31, pulse clr_req, wr_en to r3 during clear: busy 32 cycles, write dropped, all reads 0 afterwards.
// - Drop rst_n at clear cycle 10: rd_data=0 immediately, busy stays 1, full 32-cycle clear restarts on release.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file with registered read ports and a clear sequencer that zeroes
// every entry after reset or on request. Define REGFILE_BYPASS_EN for write-first forwarding.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StClear, StReady} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                wr_ok;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StClear: begin
        // Pointer holds at the last entry; READY reloads it on the next request.
        if (clr_ptr_q == '1) begin
          state_d = StReady;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      StReady: begin
        if (clr_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign busy  = (state_q == StClear);
  assign wr_ok = (state_q == StReady) && wr_en && !(ZERO_REG && (wr_addr == '0));

  // Array is not reset; the clear sequence defines its contents.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_d, rd_q;

    assign ra = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd_d = mem_q[ra];
      if (busy || (ZERO_REG && (ra == '0))) begin
        rd_d = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_ok && (ra == wr_addr)) begin
        rd_d = wr_data;
`endif
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: two instances (zero register on/off) share stimulus
// and are compared against an array-based reference model plus a fixed vector table.
module tb_regfile_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     clr_req = 1'b0;
  logic                     wr_en = 1'b0;
  logic [ADDR_W-1:0]        wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data_z, rd_data_n;
  logic                     busy_z, busy_n;

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1'b1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_z), .busy(busy_z)
  );

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1'b0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: plain arrays plus a count of remaining clear cycles.
  logic [DATA_W-1:0] mem_z [DEPTH];
  logic [DATA_W-1:0] mem_n [DEPTH];
  logic [DATA_W-1:0] exp_z [NUM_RD];
  logic [DATA_W-1:0] exp_n [NUM_RD];
  int                clr_left;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra0, ra1;
    logic [DATA_W-1:0] ez0, ez1, en0, en1;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    clr_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      mem_z[i] = '0;
      mem_n[i] = '0;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      exp_z[p] = '0;
      exp_n[p] = '0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk($sformatf("%s busy_z", tag), DATA_W'(busy_z), DATA_W'(clr_left > 0));
    chk($sformatf("%s busy_n", tag), DATA_W'(busy_n), DATA_W'(clr_left > 0));
    for (int p = 0; p < NUM_RD; p++) begin
      chk($sformatf("%s rd_z[%0d]", tag, p), rd_data_z[p*DATA_W +: DATA_W], exp_z[p]);
      chk($sformatf("%s rd_n[%0d]", tag, p), rd_data_n[p*DATA_W +: DATA_W], exp_n[p]);
    end
  endtask

  // Advance one clock edge, predicting outputs from the inputs presented before it.
  task automatic cycle(input string tag);
    logic [ADDR_W-1:0] a;
    if (clr_left > 0) begin
      for (int p = 0; p < NUM_RD; p++) begin
        exp_z[p] = '0;
        exp_n[p] = '0;
      end
      clr_left--;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        a = rd_addr[p*ADDR_W +: ADDR_W];
        exp_z[p] = (a == 0) ? '0 : mem_z[a];
        exp_n[p] = mem_n[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && a == wr_addr) begin
          exp_n[p] = wr_data;
          if (a != 0) exp_z[p] = wr_data;
        end
`endif
      end
      if (wr_en) begin
        mem_n[wr_addr] = wr_data;
        if (wr_addr != 0) mem_z[wr_addr] = wr_data;
      end
      if (clr_req) begin
        clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          mem_z[i] = '0;
          mem_n[i] = '0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    wr_en = 1'b0;
    while (busy_z && cnt < 40) begin
      cycle(tag);
      cnt++;
    end
    chk($sformatf("%s busy_cycles", tag), DATA_W'(cnt), DATA_W'(DEPTH));
  endtask

  task automatic read_all(input string tag);
    wr_en   = 1'b0;
    clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = {ADDR_W'(DEPTH - 1 - i), ADDR_W'(i)};
      cycle(tag);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk($sformatf("%s async busy", tag), DATA_W'(busy_z), DATA_W'(1));
    chk($sformatf("%s async rd_z", tag), rd_data_z[DATA_W-1:0], '0);
    chk($sformatf("%s async rd_n", tag), rd_data_n[DATA_W-1:0], '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_outputs($sformatf("%s released", tag));
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 5'd0, 32'h12345678, 5'd5, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0, 32'h0, 32'h0, 32'h12345678, 32'h12345678};
`ifdef REGFILE_BYPASS_EN
    vecs[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5,
                32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
`else
    vecs[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5,
                32'h00000001, 32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF};
`endif
    vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h12345678};

    // Reset and initial clear.
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    count_busy("init_clear");
    read_all("init_read");

    // Fixed vectors.
    for (int i = 0; i < 5; i++) begin
      wr_en   = vecs[i].we;
      wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tz0", i), rd_data_z[0 +: DATA_W], vecs[i].ez0);
      chk($sformatf("vec%0d tz1", i), rd_data_z[DATA_W +: DATA_W], vecs[i].ez1);
      chk($sformatf("vec%0d tn0", i), rd_data_n[0 +: DATA_W], vecs[i].en0);
      chk($sformatf("vec%0d tn1", i), rd_data_n[DATA_W +: DATA_W], vecs[i].en1);
    end

    // Fill r1..r31, request a clear, attempt a write to r3 while clearing.
    for (int i = 1; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = $urandom;
      rd_addr = {ADDR_W'($urandom_range(0, DEPTH - 1)), ADDR_W'(i - 1)};
      cycle("fill");
    end
    wr_en   = 1'b0;
    clr_req = 1'b1;
    cycle("clr_pulse");
    clr_req = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hBAD0BAD0;
    rd_addr = {5'd3, 5'd3};
    begin
      int cnt;
      cnt = 0;
      while (busy_z && cnt < 40) begin
        clr_req = (cnt == 5);  // ignored mid-clear
        cycle("clr_run");
        cnt++;
      end
      clr_req = 1'b0;
      chk("clr busy_cycles", DATA_W'(cnt), DATA_W'(DEPTH));
    end
    read_all("clr_read");

    // Async reset in READY with non-zero read data held.
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'hCAFEF00D;
    rd_addr = '0;
    cycle("pre_rst_wr");
    wr_en   = 1'b0;
    rd_addr = {5'd9, 5'd9};
    cycle("pre_rst_rd");
    async_reset("ready_rst");
    count_busy("ready_rst_clear");

    // Async reset at clear cycle 10.
    clr_req = 1'b1;
    cycle("mid_pulse");
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) cycle("mid_run");
    async_reset("mid_rst");
    count_busy("mid_rst_clear");
    read_all("mid_read");

    // Randomised traffic with narrow addresses to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = ADDR_W'($urandom_range(0, 7));
      wr_data = $urandom;
      rd_addr = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
      clr_req = ($urandom_range(0, 63) == 0);
      cycle("rand");
    end
    clr_req = 1'b0;
    wr_en   = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
